// File: rtl/pwm_ctrl_input.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ctrl_input
//  Description : Front-panel controller for the PWM generator. Synchronises
//                and debounces UP/DN/FREQ pushbuttons, steps the duty code
//                with auto-repeat on UP/DN, cycles the frequency select on
//                FREQ, and pulses o_update when either output changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_ctrl_input #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16,
   parameter int DUTY_MAX        = 10
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_btn_up,
   input  logic       i_btn_dn,
   input  logic       i_btn_freq,
   output logic [3:0] o_duty,
   output logic [1:0] o_freq,
   output logic       o_update
);

   localparam int                c_DW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_DW-1:0]   c_DLAST    = c_DW'(DEBOUNCE_CYCLES - 1);
   localparam int                c_HW       = $clog2(REPEAT_DELAY + 1);
   localparam logic [c_HW-1:0]   c_HDELAY   = c_HW'(REPEAT_DELAY);
   // Reloading to DELAY-RATE+1 makes the counter hit DELAY again RATE cycles later.
   localparam logic [c_HW-1:0]   c_HRELOAD  = c_HW'(REPEAT_DELAY - REPEAT_RATE + 1);
   localparam logic [3:0]        c_DUTY_MAX = 4'(DUTY_MAX);

   // Button index: 0 = UP, 1 = DN, 2 = FREQ.
   logic [2:0] w_raw;
   logic [2:0] w_db;
   logic [2:0] w_press;
   logic [1:0] w_rep;

   assign w_raw = {i_btn_freq, i_btn_dn, i_btn_up};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         logic            r_s1;
         logic            r_s2;
         logic            r_db;
         logic            r_db_q;
         logic [c_DW-1:0] r_dcnt;

         // Two-FF synchroniser followed by a stability-run debouncer.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_s1   <= 1'b0;
               r_s2   <= 1'b0;
               r_db   <= 1'b0;
               r_db_q <= 1'b0;
               r_dcnt <= '0;
            end else begin
               r_s1   <= w_raw[gi];
               r_s2   <= r_s1;
               r_db_q <= r_db;
               if (r_s2 == r_db) begin
                  r_dcnt <= '0;
               end else if (r_dcnt == c_DLAST) begin
                  r_db   <= r_s2;
                  r_dcnt <= '0;
               end else begin
                  r_dcnt <= r_dcnt + 1'b1;
               end
            end
         end

         assign w_db[gi]    = r_db;
         assign w_press[gi] = r_db & ~r_db_q;
      end
   endgenerate

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rep
         logic [c_HW-1:0] r_hcnt;

         assign w_rep[gi] = w_db[gi] && (r_hcnt == c_HDELAY);

         // Hold counter: idle while released, fires a repeat at DELAY then every RATE.
         always_ff @(posedge i_clk) begin
            if (i_rst || !w_db[gi]) begin
               r_hcnt <= '0;
            end else if (w_rep[gi]) begin
               r_hcnt <= c_HRELOAD;
            end else begin
               r_hcnt <= r_hcnt + 1'b1;
            end
         end
      end
   endgenerate

   logic       w_up_step;
   logic       w_dn_step;
   logic [3:0] w_duty_nxt;
   logic [1:0] w_freq_nxt;

   // Step arbitration: simultaneous UP and DN cancel; duty saturates at both ends.
   always_comb begin
      w_up_step  = w_press[0] | w_rep[0];
      w_dn_step  = w_press[1] | w_rep[1];
      w_duty_nxt = o_duty;
      w_freq_nxt = o_freq;
      if (w_up_step && !w_dn_step && (o_duty < c_DUTY_MAX)) begin
         w_duty_nxt = o_duty + 4'd1;
      end else if (w_dn_step && !w_up_step && (o_duty != 4'd0)) begin
         w_duty_nxt = o_duty - 4'd1;
      end
      if (w_press[2]) begin
         w_freq_nxt = o_freq + 2'd1;
      end
   end

   // Output registers; o_update flags only real value changes.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_duty   <= 4'd0;
         o_freq   <= 2'd0;
         o_update <= 1'b0;
      end else begin
         o_duty   <= w_duty_nxt;
         o_freq   <= w_freq_nxt;
         o_update <= (w_duty_nxt != o_duty) || (w_freq_nxt != o_freq);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwm_ctrl_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_ctrl_input
//  Description : Directed self-checking bench for pwm_ctrl_input at default
//                parameters (D=16, delay 64, rate 16, duty max 10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ctrl_input;

   logic       clk;
   logic       rst;
   logic       btn_up;
   logic       btn_dn;
   logic       btn_freq;
   logic [3:0] duty;
   logic [1:0] freq;
   logic       update;

   int errors = 0;
   int checks = 0;
   int pulse_at[$];
   int total;

   pwm_ctrl_input dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_btn_up   (btn_up),
      .i_btn_dn   (btn_dn),
      .i_btn_freq (btn_freq),
      .o_duty     (duty),
      .o_freq     (freq),
      .o_update   (update)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n cycles, recording which cycle (1-based edge count) pulsed o_update.
   task automatic watch(input int n);
      pulse_at.delete();
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (update === 1'b1) pulse_at.push_back(i);
      end
   endtask

   function automatic int pulse(input int k);
      return (pulse_at.size() > k) ? pulse_at[k] : -1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Press-and-release of one button: held 30, gap 30; returns pulses seen.
   task automatic tap(input int which, output int pulses);
      if (which == 0) btn_up = 1'b1;
      else if (which == 1) btn_dn = 1'b1;
      else btn_freq = 1'b1;
      watch(30);
      pulses = pulse_at.size();
      btn_up = 1'b0; btn_dn = 1'b0; btn_freq = 1'b0;
      watch(30);
      pulses += pulse_at.size();
   endtask

   initial begin
      int p;
      int exp_freq [5];
      exp_freq = '{1, 2, 3, 0, 1};
      rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0; btn_freq = 1'b0;

      // Reset state
      do_reset();
      check("reset_duty", duty, 4'd0);
      check("reset_freq", freq, 2'd0);
      check("reset_update", update, 1'b0);

      // 1: glitch shorter than debounce window
      btn_up = 1'b1;
      watch(10);
      p = pulse_at.size();
      btn_up = 1'b0;
      watch(30);
      p += pulse_at.size();
      check("glitch_pulses", p, 0);
      check("glitch_duty", duty, 4'd0);

      // 2: single press, latency 19
      do_reset();
      btn_up = 1'b1;
      watch(40);
      check("press_pulses", pulse_at.size(), 1);
      check("press_latency", pulse(0), 19);
      check("press_duty", duty, 4'd1);
      btn_up = 1'b0;
      watch(30);
      check("release_pulses", pulse_at.size(), 0);

      // 3: auto-repeat and saturation
      do_reset();
      btn_up = 1'b1;
      watch(1000);
      check("rep_count", pulse_at.size(), 10);
      check("rep_first", pulse(0), 19);
      check("rep_second", pulse(1), 83);
      check("rep_third", pulse(2), 99);
      check("rep_fourth", pulse(3), 115);
      check("rep_tenth", pulse(9), 211);
      check("rep_sat_duty", duty, 4'd10);
      btn_up = 1'b0;
      watch(30);

      // 4: FREQ cycling with wrap
      for (int k = 0; k < 5; k++) begin
         tap(2, p);
         check("freq_pulses", p, 1);
         check("freq_value", freq, exp_freq[k]);
      end
      check("freq_duty_kept", duty, 4'd10);

      // 5: bring duty to 5, then UP+DN together cancel
      for (int k = 0; k < 5; k++) begin
         tap(1, p);
         check("dn_pulses", p, 1);
      end
      check("dn_duty", duty, 4'd5);
      btn_up = 1'b1; btn_dn = 1'b1;
      watch(40);
      check("both_pulses", pulse_at.size(), 0);
      check("both_duty", duty, 4'd5);
      btn_up = 1'b0; btn_dn = 1'b0;
      watch(30);

      // 6: reset mid-hold
      do_reset();
      btn_up = 1'b1;
      watch(100);
      check("hold_pulses", pulse_at.size(), 3);
      check("hold_duty", duty, 4'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_duty", duty, 4'd0);
      check("midrst_freq", freq, 2'd0);
      check("midrst_update", update, 1'b0);
      watch(30);
      check("midrst_pulses", pulse_at.size(), 1);
      check("midrst_latency", pulse(0), 19);
      check("midrst_duty_after", duty, 4'd1);
      btn_up = 1'b0;
      watch(30);

      // DN down to 0, then DN at 0 is silent
      tap(1, p);
      check("dn_to_zero_pulses", p, 1);
      check("dn_to_zero_duty", duty, 4'd0);
      tap(1, p);
      total = p;
      check("dn_sat_pulses", total, 0);
      check("dn_sat_duty", duty, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
